button_input_conditioner: RTL and testbench

- Front-end that conditions raw board inputs for the game core.
- Synchronizes and debounces the push buttons and generates one-cycle press pulses; output drives the core's btn_pulse input directly.
- Also synchronizes the slide switches into the clock domain to produce the core's sw input.
- Sits between the board pins and the game core; one instance per board.

---
 rtl/button_input_conditioner.sv | 161 ++++++++++++++++
 tb/tb_button_input_conditioner.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_input_conditioner.sv
// button_input_conditioner
// Conditions raw board inputs for the game core. Each push button is
// synchronized and debounced, and a one-cycle pulse is produced per accepted
// press. Each slide switch is synchronized without debouncing.
// Optional macro BTN_AUTOREPEAT_EN: a held button emits repeat pulses,
// the first after REPEAT_DELAY cycles and then one every REPEAT_PERIOD cycles.
module button_input_conditioner #(
  parameter int NUM_BTN         = 5,
  parameter int SW_WIDTH        = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTN-1:0]  btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic [NUM_BTN-1:0]  btn_level,
  output logic [NUM_BTN-1:0]  btn_pulse,
  output logic [SW_WIDTH-1:0] sw_sync
);

  // Reject parameter values the logic below does not support.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
    $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] RD_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RP_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {UP, HELD, REPEAT} press_state_t;
  logic [HOLD_W-1:0] hold_cnt [NUM_BTN];
`else
  typedef enum logic {UP, HELD} press_state_t;
`endif

  logic [NUM_BTN-1:0]  btn_chain [SYNC_STAGES];
  logic [SW_WIDTH-1:0] sw_chain  [SYNC_STAGES];
  logic [NUM_BTN-1:0]  btn_sync;
  logic [CNT_W-1:0]    deb_cnt   [NUM_BTN];
  logic [CNT_W-1:0]    cnt_next  [NUM_BTN];
  logic [NUM_BTN-1:0]  level_next;
  press_state_t        state     [NUM_BTN];

  assign btn_sync = btn_chain[SYNC_STAGES-1];
  assign sw_sync  = sw_chain[SYNC_STAGES-1];

  // Synchronizer chains for buttons and switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        btn_chain[i] <= '0;
        sw_chain[i]  <= '0;
      end
    end else begin
      btn_chain[0] <= btn_raw;
      sw_chain[0]  <= sw_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        btn_chain[i] <= btn_chain[i-1];
        sw_chain[i]  <= sw_chain[i-1];
      end
    end
  end

  // Next debounced level and counter: any agreement with btn_sync restarts the count.
  always_comb begin
    level_next = btn_level;
    for (int unsigned b = 0; b < NUM_BTN; b++) begin
      cnt_next[b] = '0;
      if (btn_sync[b] != btn_level[b]) begin
        if (deb_cnt[b] == DEB_LAST) begin
          level_next[b] = ~btn_level[b];
        end else begin
          cnt_next[b] = deb_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= '0;
      for (int unsigned b = 0; b < NUM_BTN; b++) deb_cnt[b] <= '0;
    end else begin
      btn_level <= level_next;
      for (int unsigned b = 0; b < NUM_BTN; b++) deb_cnt[b] <= cnt_next[b];
    end
  end

  // Per-button press FSM; the FSM looks at level_next so the press pulse
  // lands in the same cycle btn_level first reads 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_pulse <= '0;
      for (int unsigned b = 0; b < NUM_BTN; b++) begin
        state[b] <= UP;
`ifdef BTN_AUTOREPEAT_EN
        hold_cnt[b] <= '0;
`endif
      end
    end else begin
      btn_pulse <= '0;
      for (int unsigned b = 0; b < NUM_BTN; b++) begin
        case (state[b])
          UP: begin
            if (level_next[b] && !btn_level[b]) begin
              state[b]     <= HELD;
              btn_pulse[b] <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              hold_cnt[b]  <= '0;
`endif
            end
          end
          HELD: begin
            if (!level_next[b]) begin
              state[b] <= UP;
`ifdef BTN_AUTOREPEAT_EN
              hold_cnt[b] <= '0;
            end else if (hold_cnt[b] == RD_LAST) begin
              state[b]     <= REPEAT;
              btn_pulse[b] <= 1'b1;
              hold_cnt[b]  <= '0;
            end else begin
              hold_cnt[b] <= hold_cnt[b] + 1'b1;
`endif
            end
          end
`ifdef BTN_AUTOREPEAT_EN
          REPEAT: begin
            if (!level_next[b]) begin
              state[b]    <= UP;
              hold_cnt[b] <= '0;
            end else if (hold_cnt[b] == RP_LAST) begin
              btn_pulse[b] <= 1'b1;
              hold_cnt[b]  <= '0;
            end else begin
              hold_cnt[b] <= hold_cnt[b] + 1'b1;
            end
          end
`endif
          default: state[b] <= UP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_input_conditioner.sv
// Directed testbench for button_input_conditioner
// (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_DELAY=8, REPEAT_PERIOD=3).
// Edge e is the e-th rising clk edge after the stimulus changes; outputs are
// sampled 1 time unit after each edge.
module tb_button_input_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  btn_raw;
  logic [15:0] sw_raw;
  logic [4:0]  btn_level;
  logic [4:0]  btn_pulse;
  logic [15:0] sw_sync;

  int total = 0;
  int bad   = 0;

  button_input_conditioner #(
    .NUM_BTN(5),
    .SW_WIDTH(16),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .sw_raw(sw_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .sw_sync(sw_sync)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_raw = '0;
    sw_raw = '0;
    #2;
    total++;
    if ({btn_level, btn_pulse, sw_sync} !== 26'd0) begin
      bad++;
      $display("FAIL reset_async level=%b pulse=%b sw=%h exp=0", btn_level, btn_pulse, sw_sync);
    end
    step();
    step();
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      total++;
      if ({btn_level, btn_pulse, sw_sync} !== 26'd0) begin
        bad++;
        $display("FAIL reset_idle e=%0d level=%b pulse=%b sw=%h exp=0", e, btn_level, btn_pulse, sw_sync);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [4:0] el, ep;
    btn_raw = 5'b00100;
    for (int e = 1; e <= 20; e++) begin
      step();
      el = (e >= 6) ? 5'b00100 : 5'b00000;
      ep = (e == 6) ? 5'b00100 : 5'b00000;
      total++;
      if (btn_level !== el || btn_pulse !== ep) begin
        bad++;
        $display("FAIL clean_press e=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b", e, btn_level, btn_pulse, el, ep);
      end
    end
    btn_raw = '0;
    for (int e = 1; e <= 10; e++) begin
      step();
      el = (e < 6) ? 5'b00100 : 5'b00000;
      total++;
      if (btn_level !== el || btn_pulse !== 5'b00000) begin
        bad++;
        $display("FAIL clean_release e=%0d level=%b pulse=%b exp_level=%b exp_pulse=00000", e, btn_level, btn_pulse, el);
      end
    end
  endtask

  task automatic test_glitch();
    logic [4:0] el, ep;
    btn_raw = 5'b00001;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) btn_raw = '0;
      step();
      total++;
      if (btn_level !== 5'b0 || btn_pulse !== 5'b0) begin
        bad++;
        $display("FAIL glitch_short e=%0d level=%b pulse=%b exp=00000", e, btn_level, btn_pulse);
      end
    end
    btn_raw = 5'b00001;
    for (int e = 1; e <= 14; e++) begin
      if (e == 5) btn_raw = '0;
      step();
      el = (e >= 6 && e <= 9) ? 5'b00001 : 5'b00000;
      ep = (e == 6) ? 5'b00001 : 5'b00000;
      total++;
      if (btn_level !== el || btn_pulse !== ep) begin
        bad++;
        $display("FAIL glitch_min e=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b", e, btn_level, btn_pulse, el, ep);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] el, ep;
    logic [4:0] pat [5];
    pat[0] = 5'b01000; pat[1] = 5'b00000; pat[2] = 5'b01000;
    pat[3] = 5'b00000; pat[4] = 5'b01000;
    for (int e = 1; e <= 14; e++) begin
      btn_raw = (e <= 5) ? pat[e-1] : 5'b01000;
      step();
      el = (e >= 10) ? 5'b01000 : 5'b00000;
      ep = (e == 10) ? 5'b01000 : 5'b00000;
      total++;
      if (btn_level !== el || btn_pulse !== ep) begin
        bad++;
        $display("FAIL bounce e=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b", e, btn_level, btn_pulse, el, ep);
      end
    end
    btn_raw = '0;
    for (int e = 1; e <= 8; e++) step();
    total++;
    if (btn_level !== 5'b0 || btn_pulse !== 5'b0) begin
      bad++;
      $display("FAIL bounce_release level=%b pulse=%b exp=00000", btn_level, btn_pulse);
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] el, ep;
    btn_raw = 5'b10010;
    for (int e = 1; e <= 10; e++) begin
      step();
      el = (e >= 6) ? 5'b10010 : 5'b00000;
      ep = (e == 6) ? 5'b10010 : 5'b00000;
      total++;
      if (btn_level !== el || btn_pulse !== ep) begin
        bad++;
        $display("FAIL simultaneous e=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b", e, btn_level, btn_pulse, el, ep);
      end
    end
    btn_raw = '0;
    for (int e = 1; e <= 8; e++) step();
    total++;
    if (btn_level !== 5'b0) begin
      bad++;
      $display("FAIL simultaneous_release level=%b exp=00000", btn_level);
    end
  endtask

  task automatic test_switch_sync();
    sw_raw = 16'hA5C3;
    step();
    total++;
    if (sw_sync !== 16'h0000) begin
      bad++;
      $display("FAIL sw_edge1 sw=%h exp=0000", sw_sync);
    end
    step();
    total++;
    if (sw_sync !== 16'hA5C3) begin
      bad++;
      $display("FAIL sw_edge2 sw=%h exp=a5c3", sw_sync);
    end
    sw_raw = 16'h3C5A;
    step();
    step();
    total++;
    if (sw_sync !== 16'h3C5A) begin
      bad++;
      $display("FAIL sw_change sw=%h exp=3c5a", sw_sync);
    end
    sw_raw = 16'hA5C3;
    step();
    step();
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] el, ep;
    btn_raw = 5'b00100;
    for (int e = 1; e <= 10; e++) step();
    total++;
    if (btn_level !== 5'b00100 || sw_sync !== 16'hA5C3) begin
      bad++;
      $display("FAIL pre_reset level=%b sw=%h exp_level=00100 exp_sw=a5c3", btn_level, sw_sync);
    end
    rst = 1'b1;
    #2;
    total++;
    if (btn_level !== 5'b0 || btn_pulse !== 5'b0 || sw_sync !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid_hold level=%b pulse=%b sw=%h exp=0", btn_level, btn_pulse, sw_sync);
    end
    step();
    step();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      el = (e >= 6) ? 5'b00100 : 5'b00000;
      ep = (e == 6) ? 5'b00100 : 5'b00000;
      total++;
      if (btn_level !== el || btn_pulse !== ep) begin
        bad++;
        $display("FAIL post_reset e=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b", e, btn_level, btn_pulse, el, ep);
      end
      if (e == 2) begin
        total++;
        if (sw_sync !== 16'hA5C3) begin
          bad++;
          $display("FAIL post_reset_sw sw=%h exp=a5c3", sw_sync);
        end
      end
    end
    btn_raw = '0;
    for (int e = 1; e <= 8; e++) step();
  endtask

  task automatic test_autorepeat();
    logic [4:0] el, ep;
    logic       rep;
    btn_raw = 5'b00001;
    for (int e = 1; e <= 40; e++) begin
      if (e == 31) btn_raw = '0;
      step();
`ifdef BTN_AUTOREPEAT_EN
      rep = (e == 6) || (e >= 14 && e <= 35 && ((e - 14) % 3 == 0));
`else
      rep = (e == 6);
`endif
      el = (e >= 6 && e <= 35) ? 5'b00001 : 5'b00000;
      ep = rep ? 5'b00001 : 5'b00000;
      total++;
      if (btn_level !== el || btn_pulse !== ep) begin
        bad++;
        $display("FAIL autorepeat e=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b", e, btn_level, btn_pulse, el, ep);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_switch_sync();
    test_reset_mid_hold();
    test_autorepeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
